apb_master: RTL and testbench
=============================

# apb_master

Single-outstanding APB3 requester that converts a valid/ready command stream into APB SETUP/ACCESS transfers and returns one response per command. It sits directly upstream of the APB register/memory slave: its APB outputs drive the slave's `paddr`/`psel`/`pwrite`/`pwdata`/`penable` inputs, and it samples the slave's `prdata`. Slaves without a ready output have `i_pready` tied high. A wait-state timeout guarantees forward progress.

## Interface
- `ADDR_W`, default 32: APB address width.
- `DATA_W`, default 32: APB data width.
- `TIMEOUT`, default 16: maximum number of ACCESS cycles with `i_pready` low before the transfer is aborted. Must be ≥1.

Ports (name, direction, width, meaning):
- `i_clk` in 1: sole clock, rising edge.
- `i_rst` in 1: synchronous, active-high reset.
- `i_cmd_valid` in 1: command offered.
- `o_cmd_ready` out 1: command accepted on the edge where `i_cmd_valid & o_cmd_ready`.
- `i_cmd_write` in 1: 1 = write, 0 = read.
- `i_cmd_addr` in ADDR_W: transfer address.
- `i_cmd_wdata` in DATA_W: write data; ignored for reads.
- `o_rsp_valid` out 1: one-cycle response pulse; no backpressure.
- `o_rsp_rdata` out DATA_W: read data, valid with `o_rsp_valid`.
- `o_rsp_err` out 1: timeout flag, valid with `o_rsp_valid`.
- `o_paddr` out ADDR_W, `o_pwrite` out 1, `o_pwdata` out DATA_W: APB address and control.
- `o_psel` out 1, `o_penable` out 1: APB phase signals.
- `i_prdata` in DATA_W: slave read data; may be combinational from the slave.
- `i_pready` in 1: slave ready; tie to 1 if the slave has none.

## Operation
The FSM has three states: IDLE, SETUP and ACCESS.
- **IDLE:** `o_cmd_ready`=1, `o_psel`=0, `o_penable`=0.
  - On accept, register `addr`/`write`/`wdata` into `o_paddr`/`o_pwrite`/`o_pwdata` and go to SETUP.
- **SETUP:** `o_psel`=1, `o_penable`=0, `o_cmd_ready`=0.
  - Unconditionally go to ACCESS.
  - Clear the wait counter.
- **ACCESS:** `o_psel`=1, `o_penable`=1.
  - If `i_pready`=1: complete and go to IDLE.
    - Capture `i_prdata` into `o_rsp_rdata` for reads; writes return 0.
    - Next cycle: `o_rsp_valid`=1, `o_rsp_err`=0.
  - Else if the wait counter equals `TIMEOUT`-1: abort and go to IDLE.
    - Next cycle: `o_rsp_valid`=1, `o_rsp_err`=1, `o_rsp_rdata`=0.
  - Else: increment the wait counter and stay in ACCESS.
- **APB stability:** `o_paddr`, `o_pwrite` and `o_pwdata` hold stable from SETUP through the final ACCESS cycle. They retain their last value in IDLE.
- **Response hold:** `o_rsp_rdata` and `o_rsp_err` hold their values until the next response.
- **Commands:** exactly one response per accepted command. Commands are never reordered or dropped, except on reset.
- **Reset:** clears all state immediately, including mid-transfer. The in-flight command produces no response.
- **Reset values:** state=IDLE, `o_cmd_ready`=0 during reset and 1 the first cycle after, `o_psel`=0, `o_penable`=0, `o_paddr`=0, `o_pwrite`=0, `o_pwdata`=0, `o_rsp_valid`=0, `o_rsp_rdata`=0, `o_rsp_err`=0, wait counter=0.

## Timing
- **Zero-wait transfer:** accept at edge N, SETUP in cycle N+1, ACCESS in cycle N+2, `o_rsp_valid` in cycle N+3.
- **Throughput:** `o_cmd_ready` reasserts in cycle N+3. Back-to-back throughput is 1 command per 3 cycles.
- **Wait states:** each cycle with `i_pready` low adds one cycle to the latency.
- **Timeout:** ACCESS lasts exactly `TIMEOUT` cycles, then `o_rsp_valid` with `o_rsp_err`=1 follows.
- **Sampling point:** `i_prdata` is sampled only at the completing ACCESS edge. It is don't-care at all other times.
- **Response/accept overlap:** `o_rsp_valid` and a new accept may occur in the same cycle.
- **Wait counter width:** `$clog2(TIMEOUT+1)` bits, saturating. It never wraps.
- All outputs are registered.

## Structure
- Package `apb_pkg` holds:
  - the state typedef `apb_state_t` (IDLE, SETUP, ACCESS);
  - localparams for the default `ADDR_W`/`DATA_W`;
  - the default `TIMEOUT`.
- One sub-module: `apb_wait_timer`.
  - Inputs: clear, enable.
  - Output: a terminal-count flag at `TIMEOUT`-1.
  - Synchronous active-high reset.
- Everything else is in the top module.

## Test plan
The bench connects this block to the 256-deep APB slave with `i_pready` tied to 1 unless stated otherwise.
- **Write then read:** write `0xDEADBEEF` to addr `0x10`, then read `0x10`.
  - Write: `o_psel`/`o_penable` follow the SETUP→ACCESS sequence; response with `rdata`=0, err=0.
  - Read: response `rdata`=`0xDEADBEEF` at accept+3, err=0.
- **Back-to-back stream:** `i_cmd_valid` held high over 4 writes to addrs 0–3 with data 1–4, then 4 reads.
  - `o_cmd_ready` pulses every 3 cycles.
  - Reads return 1, 2, 3, 4 in order.
- **Wait states:** `i_pready` low for 3 ACCESS cycles on a read of `0x20`, which holds `0x55`.
  - `paddr`/`psel`/`penable` stay stable throughout.
  - Response `0x55` at accept+6.
- **Timeout:** `TIMEOUT`=4, `i_pready` stuck at 0.
  - ACCESS lasts exactly 4 cycles.
  - Response with err=1, `rdata`=0.
  - The next command with `pready`=1 completes normally.
- **Reset mid-ACCESS:** `i_rst` asserted during ACCESS of a write to `0x30`.
  - Next cycle: `psel`=0, `penable`=0, no `o_rsp_valid`.
  - `o_cmd_ready`=1 the cycle after reset deasserts.
- **Idle behaviour:** `i_cmd_valid`=0 for 20 cycles.
  - `psel`, `penable` and `rsp_valid` remain 0.
  - `o_cmd_ready` stays 1.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and default parameters for the APB requester and its helpers.
package apb_pkg;

    // Transfer phases of the APB requester.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    localparam int APB_ADDR_W  = 32;
    localparam int APB_DATA_W  = 32;
    localparam int APB_TIMEOUT = 16;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait states and flags when the last allowed wait cycle is reached.
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int TIMEOUT = APB_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] MAX  = CW'(TIMEOUT);

    logic [CW-1:0] count;

    // Saturating wait counter: cleared at the start of each transfer, never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != MAX)) begin
            count <= count + CW'(1);
        end
    end

    assign terminal = (count == LAST);

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB3 requester: turns a valid/ready command stream into
// SETUP/ACCESS transfers and returns one registered response per command.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = APB_TIMEOUT
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_write,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [DATA_W-1:0] i_cmd_wdata,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err,
    output logic [ADDR_W-1:0] o_paddr,
    output logic              o_pwrite,
    output logic [DATA_W-1:0] o_pwdata,
    output logic              o_psel,
    output logic              o_penable,
    input  logic [DATA_W-1:0] i_prdata,
    input  logic              i_pready
);

    apb_state_t state;
    apb_state_t next_state;

    logic accept;
    logic timer_clear;
    logic timer_enable;
    logic timer_terminal;
    logic done_ok;
    logic done_timeout;

    logic psel_d;
    logic penable_d;
    logic ready_d;

    // o_cmd_ready is only high while idle, so it alone qualifies an accept.
    assign accept       = i_cmd_valid & o_cmd_ready;
    assign timer_clear  = (state == SETUP);
    assign timer_enable = (state == ACCESS) & ~i_pready;
    assign done_ok      = (state == ACCESS) & i_pready;
    assign done_timeout = (state == ACCESS) & ~i_pready & timer_terminal;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk      (i_clk),
        .rst      (i_rst),
        .clear    (timer_clear),
        .enable   (timer_enable),
        .terminal (timer_terminal)
    );

    // State register; phase outputs are registered from the next-state decode.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            o_psel      <= 1'b0;
            o_penable   <= 1'b0;
            o_cmd_ready <= 1'b0;
        end else begin
            state       <= next_state;
            o_psel      <= psel_d;
            o_penable   <= penable_d;
            o_cmd_ready <= ready_d;
        end
    end

    // Next-state logic: ready slave completes, exhausted wait budget aborts.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = SETUP;
                end
            end
            SETUP: begin
                next_state = ACCESS;
            end
            ACCESS: begin
                if (i_pready || timer_terminal) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output decode for the phase the FSM is about to enter.
    always_comb begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        ready_d   = 1'b0;
        case (next_state)
            IDLE:    ready_d = 1'b1;
            SETUP:   psel_d  = 1'b1;
            ACCESS: begin
                psel_d    = 1'b1;
                penable_d = 1'b1;
            end
            default: ready_d = 1'b0;
        endcase
    end

    // Capture the accepted command; held stable until the next accept.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_paddr  <= '0;
            o_pwrite <= 1'b0;
            o_pwdata <= '0;
        end else if (accept) begin
            o_paddr  <= i_cmd_addr;
            o_pwrite <= i_cmd_write;
            o_pwdata <= i_cmd_wdata;
        end
    end

    // One-cycle response pulse; data and error hold until the next response.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= '0;
            o_rsp_err   <= 1'b0;
        end else begin
            o_rsp_valid <= done_ok | done_timeout;
            if (done_ok) begin
                o_rsp_rdata <= o_pwrite ? '0 : i_prdata;
                o_rsp_err   <= 1'b0;
            end else if (done_timeout) begin
                o_rsp_rdata <= '0;
                o_rsp_err   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master against a 256-deep behavioural APB slave.
module tb_apb_master;

    localparam int TO = 4;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_cmd_valid = 1'b0;
    logic        o_cmd_ready;
    logic        i_cmd_write = 1'b0;
    logic [31:0] i_cmd_addr = '0;
    logic [31:0] i_cmd_wdata = '0;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic [31:0] o_paddr;
    logic        o_pwrite;
    logic [31:0] o_pwdata;
    logic        o_psel;
    logic        o_penable;
    logic [31:0] i_prdata;
    logic        i_pready;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int wait_cycles = 0;
    bit stuck = 1'b0;
    int acc_cnt = 0;

    logic [31:0] mem [256];
    bit          mem_loaded = 1'b0;
    logic [31:0] ref_mem [256];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          exp_cyc;
        string       tag;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        bit          stuck;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          lat;
    } vec_t;
    vec_t vecs[10];

    apb_master #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TO)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_cmd_write (i_cmd_write),
        .i_cmd_addr  (i_cmd_addr),
        .i_cmd_wdata (i_cmd_wdata),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_rdata (o_rsp_rdata),
        .o_rsp_err   (o_rsp_err),
        .o_paddr     (o_paddr),
        .o_pwrite    (o_pwrite),
        .o_pwdata    (o_pwdata),
        .o_psel      (o_psel),
        .o_penable   (o_penable),
        .i_prdata    (i_prdata),
        .i_pready    (i_pready)
    );

    always #5 i_clk = ~i_clk;

    // Edge counter used to time accepts and responses.
    always @(posedge i_clk) cyc <= cyc + 1;

    // Counts ACCESS cycles of the current transfer to shape wait states.
    always @(posedge i_clk) begin
        if (o_psel && o_penable) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    assign i_pready = !stuck && (acc_cnt >= wait_cycles);

    // Behavioural slave memory: preloaded once, written on completing write ACCESS.
    always @(posedge i_clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] = '0;
            mem[8'h20] = 32'h55;
            mem_loaded = 1'b1;
        end else if (o_psel && o_penable && o_pwrite && i_pready) begin
            mem[o_paddr[7:0]] = o_pwdata;
        end
    end

    assign i_prdata = mem[o_paddr[7:0]];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: poll the response port at the falling edge, then land 1ns past the rising edge.
    task automatic step();
        exp_t e;
        @(negedge i_clk);
        if (o_rsp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_rsp: got rdata=%0h err=%0b, expected no response", o_rsp_rdata, o_rsp_err);
            end else begin
                e = sb.pop_front();
                checkOutput({e.tag, "_rdata"}, 64'(o_rsp_rdata), 64'(e.rdata));
                checkOutput({e.tag, "_err"}, 64'(o_rsp_err), 64'(e.err));
                checkOutput({e.tag, "_cycle"}, 64'(cyc), 64'(e.exp_cyc));
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic applyStimulus(input bit write, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] exp_rdata, input bit exp_err, input int lat,
                                 input bit expect_rsp, input bit keep_valid, input string tag,
                                 output int acc_cyc);
        bit ready_now;
        bit done;
        exp_t e;
        done = 1'b0;
        acc_cyc = -1;
        i_cmd_valid = 1'b1;
        i_cmd_write = write;
        i_cmd_addr  = addr;
        i_cmd_wdata = wdata;
        for (int i = 0; i < 30 && !done; i++) begin
            ready_now = o_cmd_ready;
            step();
            if (ready_now) begin
                done = 1'b1;
                acc_cyc = cyc;
                if (expect_rsp) begin
                    e.rdata = exp_rdata;
                    e.err = exp_err;
                    e.exp_cyc = cyc + lat - 1;
                    e.tag = tag;
                    sb.push_back(e);
                end
            end
        end
        if (!keep_valid || !done) i_cmd_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_accept: got no accept in 30 cycles, expected accept", tag);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() > 0; i++) step();
        checkOutput("drain_empty", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    initial begin
        int acc;
        int prev_acc;
        int n_access;

        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        ref_mem[8'h20] = 32'h55;

        vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0, 32'h0,        1'b0, 3};
        vecs[1] = '{1'b0, 32'h10, 32'h0,        0, 1'b0, 32'hDEADBEEF, 1'b0, 3};
        vecs[2] = '{1'b0, 32'h20, 32'h0,        3, 1'b0, 32'h55,       1'b0, 6};
        vecs[3] = '{1'b0, 32'h10, 32'h0,        0, 1'b1, 32'h0,        1'b1, 6};
        vecs[4] = '{1'b1, 32'h40, 32'hA5A50001, 1, 1'b0, 32'h0,        1'b0, 4};
        vecs[5] = '{1'b0, 32'h40, 32'h0,        0, 1'b0, 32'hA5A50001, 1'b0, 3};
        vecs[6] = '{1'b1, 32'h24, 32'h12345678, 2, 1'b0, 32'h0,        1'b0, 5};
        vecs[7] = '{1'b0, 32'h24, 32'h0,        0, 1'b0, 32'h12345678, 1'b0, 3};
        vecs[8] = '{1'b1, 32'h44, 32'hCAFEF00D, 0, 1'b1, 32'h0,        1'b1, 6};
        vecs[9] = '{1'b0, 32'h44, 32'h0,        0, 1'b0, 32'h0,        1'b0, 3};

        $display("[TB] reset");
        for (int i = 0; i < 3; i++) step();
        checkOutput("rst_ready", 64'(o_cmd_ready), 64'd0);
        checkOutput("rst_psel", 64'(o_psel), 64'd0);
        checkOutput("rst_penable", 64'(o_penable), 64'd0);
        checkOutput("rst_paddr", 64'(o_paddr), 64'd0);
        checkOutput("rst_pwrite", 64'(o_pwrite), 64'd0);
        checkOutput("rst_pwdata", 64'(o_pwdata), 64'd0);
        checkOutput("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
        checkOutput("rst_rsp_rdata", 64'(o_rsp_rdata), 64'd0);
        checkOutput("rst_rsp_err", 64'(o_rsp_err), 64'd0);
        i_rst = 1'b0;
        step();
        checkOutput("ready_after_reset", 64'(o_cmd_ready), 64'd1);

        $display("[TB] table vectors");
        for (int i = 0; i < 10; i++) begin
            wait_cycles = vecs[i].waits;
            stuck = vecs[i].stuck;
            applyStimulus(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata,
                          vecs[i].exp_err, vecs[i].lat, 1'b1, 1'b0, $sformatf("v%0d", i), acc);
            checkOutput($sformatf("v%0d_setup_psel", i), 64'(o_psel), 64'd1);
            checkOutput($sformatf("v%0d_setup_penable", i), 64'(o_penable), 64'd0);
            checkOutput($sformatf("v%0d_paddr", i), 64'(o_paddr), 64'(vecs[i].addr));
            checkOutput($sformatf("v%0d_pwrite", i), 64'(o_pwrite), 64'(vecs[i].write));
            step();
            checkOutput($sformatf("v%0d_access_psel", i), 64'(o_psel), 64'd1);
            checkOutput($sformatf("v%0d_access_penable", i), 64'(o_penable), 64'd1);
            drain();
            if (vecs[i].write && !vecs[i].exp_err) ref_mem[vecs[i].addr[7:0]] = vecs[i].wdata;
            stuck = 1'b0;
            wait_cycles = 0;
        end

        $display("[TB] wait-state stability");
        wait_cycles = 3;
        applyStimulus(1'b0, 32'h20, 32'h0, ref_mem[8'h20], 1'b0, 6, 1'b1, 1'b0, "ws", acc);
        n_access = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (o_penable) begin
                n_access++;
                checkOutput("ws_psel", 64'(o_psel), 64'd1);
                checkOutput("ws_paddr", 64'(o_paddr), 64'h20);
            end
        end
        checkOutput("ws_access_cycles", 64'(n_access), 64'd4);
        drain();
        wait_cycles = 0;

        $display("[TB] timeout length");
        stuck = 1'b1;
        applyStimulus(1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 6, 1'b1, 1'b0, "to", acc);
        n_access = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (o_penable) n_access++;
        end
        checkOutput("to_access_cycles", 64'(n_access), 64'(TO));
        drain();
        stuck = 1'b0;

        $display("[TB] back-to-back stream");
        prev_acc = -1;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a;
            a = 32'(i % 4);
            if (i < 4) begin
                ref_mem[a[7:0]] = 32'(i + 1);
                applyStimulus(1'b1, a, 32'(i + 1), 32'h0, 1'b0, 3, 1'b1, (i < 7), $sformatf("bw%0d", i), acc);
            end else begin
                applyStimulus(1'b0, a, 32'h0, ref_mem[a[7:0]], 1'b0, 3, 1'b1, (i < 7), $sformatf("br%0d", i), acc);
            end
            if (i > 0) checkOutput($sformatf("b2b_spacing%0d", i), 64'(acc - prev_acc), 64'd3);
            prev_acc = acc;
        end
        drain();

        $display("[TB] reset mid-ACCESS");
        stuck = 1'b1;
        applyStimulus(1'b1, 32'h30, 32'h77, 32'h0, 1'b0, 3, 1'b0, 1'b0, "mr", acc);
        step();
        checkOutput("mr_in_access", 64'(o_penable), 64'd1);
        i_rst = 1'b1;
        step();
        checkOutput("mr_psel", 64'(o_psel), 64'd0);
        checkOutput("mr_penable", 64'(o_penable), 64'd0);
        checkOutput("mr_rsp_valid", 64'(o_rsp_valid), 64'd0);
        checkOutput("mr_ready_in_reset", 64'(o_cmd_ready), 64'd0);
        checkOutput("mr_paddr", 64'(o_paddr), 64'd0);
        i_rst = 1'b0;
        stuck = 1'b0;
        step();
        checkOutput("mr_ready_after", 64'(o_cmd_ready), 64'd1);
        for (int i = 0; i < 5; i++) step();
        applyStimulus(1'b0, 32'h30, 32'h0, ref_mem[8'h30], 1'b0, 3, 1'b1, 1'b0, "mr_read", acc);
        drain();

        $display("[TB] idle");
        for (int i = 0; i < 20; i++) begin
            step();
            checkOutput("idle_psel", 64'(o_psel), 64'd0);
            checkOutput("idle_penable", 64'(o_penable), 64'd0);
            checkOutput("idle_rsp_valid", 64'(o_rsp_valid), 64'd0);
            checkOutput("idle_ready", 64'(o_cmd_ready), 64'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
